bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter, the inverse of the `bcd2driver` binary-to-BCD path. It takes a packed multi-digit BCD value, such as a number keyed in on the switches digit by digit, and produces its unsigned binary equivalent. It uses reverse double-dabble: one shift/adjust step per clock, behind a start/done handshake. It feeds the arithmetic datapath, whose results return to the display through `bcd2driver`.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd2bin_seq.sv | 99 +++++++++
 tb/tb_bcd2bin_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } bcd_state_t;

  localparam int          BCD_NIBBLE_W   = 4;
  localparam logic [3:0]  BCD_ADJ        = 4'd3;
  localparam logic [3:0]  BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// One reverse double-dabble nibble correction: a digit that reads 8 or more
// after the right shift had a ten's bit borrowed into it, so take 3 back off.
import bcd_pkg::*;

module bcd_digit_adj (
  input  logic [BCD_NIBBLE_W-1:0] i_nibble,
  output logic [BCD_NIBBLE_W-1:0] o_nibble
);

  assign o_nibble = (i_nibble >= BCD_ADJ_THRESH) ? (i_nibble - BCD_ADJ) : i_nibble;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one reverse double-dabble shift/adjust
// step per clock behind a start/done handshake.
import bcd_pkg::*;

module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_in,
  output logic                           busy,
  output logic                           done,
  output logic [BIN_W-1:0]               bin_out,
  output logic                           err
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  bcd_state_t       r_state;
  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;

  logic [SR_W-1:0]   w_shifted;
  logic [BCD_W-1:0]  w_adj_bcd;
  logic [SR_W-1:0]   w_next_sr;
  logic [DIGITS-1:0] w_digit_bad;
  logic              w_bcd_bad;

  assign w_shifted = r_sr >> 1;

  // Each BCD digit of the shifted register gets its own correction slice.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_adj u_adj (
      .i_nibble (w_shifted[BIN_W + d*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .o_nibble (w_adj_bcd[d*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );

    assign w_digit_bad[d] = (bcd_in[d*BCD_NIBBLE_W +: BCD_NIBBLE_W] > BCD_MAX_DIGIT);
  end

  assign w_next_sr = {w_adj_bcd, w_shifted[BIN_W-1:0]};
  assign w_bcd_bad = |w_digit_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            // Illegal digits skip the conversion entirely and report at once.
            if (w_bcd_bad) begin
              bin_out <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_sr    <= {bcd_in, {BIN_W{1'b0}}};
              r_cnt   <= '0;
              r_state <= CONV;
            end
          end
        end
        CONV: begin
          r_sr  <= w_next_sr;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            bin_out <= w_next_sr[BIN_W-1:0];
            err     <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: stimulus pushes expectations, a monitor
// pops and compares them whenever done pulses.
module tb_bcd2bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [4*DIGITS-1:0] bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               lat;
    int               accept;
  } expItem_t;

  expItem_t expQ[$];
  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;
  logic prevDone = 1'b0;

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && done) begin
      checkOutput("doneWidth", {31'd0, prevDone}, 32'd0);
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedDone: got done=1 bin_out=%0d, expected no done", bin_out);
      end else begin
        expItem_t it;
        it = expQ.pop_front();
        checkOutput("binOut", 32'(bin_out), 32'(it.bin));
        checkOutput("err", {31'd0, err}, {31'd0, it.err});
        checkOutput("latency", 32'(cycleCount - it.accept), 32'(it.lat));
      end
    end
    prevDone = done;
  end

  task automatic waitIdle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clock);
    if (busy) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idleTimeout: got busy=1, expected busy=0 within 50 cycles");
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic applyStimulus(input logic [11:0] bcd, input logic [BIN_W-1:0] expBin, input logic expErr);
    expItem_t it;
    waitIdle();
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clock);
    #1;
    it.bin    = expBin;
    it.err    = expErr;
    it.lat    = expErr ? 0 : BIN_W;
    it.accept = cycleCount;
    expQ.push_back(it);
    checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulseStart(input logic [11:0] bcd);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    bcd_in  = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetErr", {31'd0, err}, 32'd0);
    checkOutput("resetBin", 32'(bin_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    applyStimulus(12'h000, 10'd0, 1'b0);
    applyStimulus(12'h127, 10'd127, 1'b0);
    applyStimulus(12'h999, 10'd999, 1'b0);

    applyStimulus(12'h1A5, 10'd0, 1'b1);
    @(negedge clock);
    checkOutput("invalidBusyOneCycle", {31'd0, busy}, 32'd0);

    // Extra starts during CONV must be ignored.
    applyStimulus(12'h250, 10'd250, 1'b0);
    repeat (2) @(negedge clock);
    pulseStart(12'h999);
    repeat (6) @(negedge clock);
    pulseStart(12'h999);
    applyStimulus(12'h251, 10'd251, 1'b0);

    // Reset mid-conversion discards the partial result.
    waitIdle();
    pulseStart(12'h555);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
    checkOutput("midResetDone", {31'd0, done}, 32'd0);
    checkOutput("midResetErr", {31'd0, err}, 32'd0);
    checkOutput("midResetBin", 32'(bin_out), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    applyStimulus(12'h042, 10'd42, 1'b0);

    applyStimulus(12'h9F9, 10'd0, 1'b1);
    applyStimulus(12'hA00, 10'd0, 1'b1);

    for (int v = 0; v < 1000; v++) begin
      logic [11:0] b;
      b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      applyStimulus(b, 10'(v), 1'b0);
    end

    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clock);
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL pendingExpect: got %0d outstanding, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
